// File: rtl/audio_pkg.sv
// Shared audio definitions: mixer FSM states, PSG ratio encodings and the output sample width.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  localparam logic [1:0] PSG_RATIO_25  = 2'd0;
  localparam logic [1:0] PSG_RATIO_50  = 2'd1;
  localparam logic [1:0] PSG_RATIO_100 = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC0  = 3'd1,
    ACC1  = 3'd2,
    ACC2  = 3'd3,
    ACC3  = 3'd4,
    SCALE = 3'd5,
    SAT   = 3'd6,
    OUT   = 3'd7
  } mix_state_t;

endpackage

// File: rtl/mix_saturate.sv
// Combinational signed clamp from an ACC_W accumulator to an OUT_W sample.
//   value      in   ACC_W  signed accumulator value
//   clamped_c  out  OUT_W  value limited to the signed OUT_W range
module mix_saturate #(
  parameter int unsigned ACC_W = 22,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] value,
  output logic signed [OUT_W-1:0] clamped_c
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (OUT_W - 1)));

  always_comb begin
    clamped_c = OUT_W'(value);
    if (value > MAX_V) begin
      clamped_c = OUT_W'(MAX_V);
    end else if (value < MIN_V) begin
      clamped_c = OUT_W'(MIN_V);
    end
  end

endmodule

// File: rtl/psg_mixer.sv
// Mixes the four PSG channels into a saturated signed left/right pair per sample_tick.
//   system_clock, reset          clock and asynchronous active-high reset
//   sample_tick                  request for a new mixed sample (taken only in IDLE)
//   ch1_wave..ch4_wave           signed channel inputs
//   NR50/NR51/NR52, psg_ratio    volume, routing, master enable and PSG ratio
//   left_sample/right_sample     signed mixed output pair
//   sample_valid / sample_ready  output handshake; pair held until accepted
//   busy, overrun                FSM active; sticky dropped-tick flag
module psg_mixer
  import audio_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = SAMPLE_W,
  parameter int unsigned ACC_W = 22
) (
  input  logic              system_clock,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [IN_W-1:0]   ch1_wave,
  input  logic [IN_W-1:0]   ch2_wave,
  input  logic [IN_W-1:0]   ch3_wave,
  input  logic [IN_W-1:0]   ch4_wave,
  input  logic [7:0]        NR50,
  input  logic [7:0]        NR51,
  input  logic [7:0]        NR52,
  input  logic [1:0]        psg_ratio,
  output logic [OUT_W-1:0]  left_sample,
  output logic [OUT_W-1:0]  right_sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned TERM_W = IN_W - 8;

  mix_state_t state;

  // Snapshot holds each channel already shifted right by 8 (top TERM_W bits).
  logic signed [TERM_W-1:0] snap [4];
  logic [7:0]               nr51_s;
  logic [2:0]               vol_l_s;
  logic [2:0]               vol_r_s;
  logic                     master_s;
  logic [1:0]               ratio_s;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W-1:0]  acc_r;

  logic signed [TERM_W-1:0] sel_term_c;
  logic                     route_l_c;
  logic                     route_r_c;
  logic signed [ACC_W-1:0]  term_c;
  logic [3:0]               vol_l_c;
  logic [3:0]               vol_r_c;
  logic signed [ACC_W-1:0]  mul_l_c;
  logic signed [ACC_W-1:0]  mul_r_c;
  logic signed [ACC_W-1:0]  scale_l_c;
  logic signed [ACC_W-1:0]  scale_r_c;
  logic signed [OUT_W-1:0]  sat_l_c;
  logic signed [OUT_W-1:0]  sat_r_c;
  logic                     unused_c;

  assign unused_c = ^{ch1_wave[7:0], ch2_wave[7:0], ch3_wave[7:0], ch4_wave[7:0],
                      NR50[7], NR50[3], NR52[6:0]};

  // Channel term and routing for the current ACC state.
  always_comb begin
    sel_term_c = '0;
    route_l_c  = 1'b0;
    route_r_c  = 1'b0;
    case (state)
      ACC0: begin sel_term_c = snap[0]; route_l_c = nr51_s[4]; route_r_c = nr51_s[0]; end
      ACC1: begin sel_term_c = snap[1]; route_l_c = nr51_s[5]; route_r_c = nr51_s[1]; end
      ACC2: begin sel_term_c = snap[2]; route_l_c = nr51_s[6]; route_r_c = nr51_s[2]; end
      ACC3: begin sel_term_c = snap[3]; route_l_c = nr51_s[7]; route_r_c = nr51_s[3]; end
      default: ;
    endcase
    term_c = master_s ? ACC_W'(sel_term_c) : '0;
  end

  // Master volume (vol+1)/8 followed by the PSG ratio shift.
  always_comb begin
    vol_l_c = {1'b0, vol_l_s} + 4'd1;
    vol_r_c = {1'b0, vol_r_s} + 4'd1;
    mul_l_c = (acc_l * $signed(ACC_W'(vol_l_c))) >>> 3;
    mul_r_c = (acc_r * $signed(ACC_W'(vol_r_c))) >>> 3;
    case (ratio_s)
      PSG_RATIO_100: begin scale_l_c = mul_l_c;        scale_r_c = mul_r_c;        end
      PSG_RATIO_50:  begin scale_l_c = mul_l_c >>> 1;  scale_r_c = mul_r_c >>> 1;  end
      default:       begin scale_l_c = mul_l_c >>> 2;  scale_r_c = mul_r_c >>> 2;  end
    endcase
  end

  mix_saturate #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_l (.value(acc_l), .clamped_c(sat_l_c));
  mix_saturate #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat_r (.value(acc_r), .clamped_c(sat_r_c));

  // Mixer FSM with registered outputs.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      nr51_s       <= '0;
      vol_l_s      <= '0;
      vol_r_s      <= '0;
      master_s     <= 1'b0;
      ratio_s      <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            snap[0]  <= $signed(ch1_wave[IN_W-1:8]);
            snap[1]  <= $signed(ch2_wave[IN_W-1:8]);
            snap[2]  <= $signed(ch3_wave[IN_W-1:8]);
            snap[3]  <= $signed(ch4_wave[IN_W-1:8]);
            nr51_s   <= NR51;
            vol_l_s  <= NR50[6:4];
            vol_r_s  <= NR50[2:0];
            master_s <= NR52[7];
            ratio_s  <= psg_ratio;
            acc_l    <= '0;
            acc_r    <= '0;
            busy     <= 1'b1;
            state    <= ACC0;
            if (!NR52[7]) overrun <= 1'b0;
          end
        end
        ACC0, ACC1, ACC2, ACC3: begin
          if (route_l_c) acc_l <= acc_l + term_c;
          if (route_r_c) acc_r <= acc_r + term_c;
          state <= mix_state_t'(3'(state) + 3'd1);
        end
        SCALE: begin
          acc_l <= scale_l_c;
          acc_r <= scale_r_c;
          state <= SAT;
        end
        SAT: begin
          left_sample  <= sat_l_c;
          right_sample <= sat_r_c;
          sample_valid <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Any tick outside IDLE (including the OUT->IDLE cycle) is dropped.
      if (sample_tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psg_mixer.sv
// Directed self-checking bench for psg_mixer with an expected-sample scoreboard.
module tb_psg_mixer;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [23:0] ch1, ch2, ch3, ch4;
  logic [7:0]  nr50, nr51, nr52;
  logic [1:0]  ratio;
  logic [15:0] left_sample, right_sample;
  logic        sample_valid, sample_ready, busy, overrun;

  int    checks = 0;
  int    errors = 0;
  pair_t sb[$];

  always #5 clk = ~clk;

  psg_mixer dut (
    .system_clock (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .ch1_wave     (ch1),
    .ch2_wave     (ch2),
    .ch3_wave     (ch3),
    .ch4_wave     (ch4),
    .NR50         (nr50),
    .NR51         (nr51),
    .NR52         (nr52),
    .psg_ratio    (ratio),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int term_of(input logic [23:0] c);
    logic signed [15:0] t;
    t = c[23:8];
    return int'(t);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference mix of the current inputs.
  function automatic pair_t model();
    int t[4];
    int l, r;
    pair_t p;
    t[0] = term_of(ch1); t[1] = term_of(ch2); t[2] = term_of(ch3); t[3] = term_of(ch4);
    l = 0; r = 0;
    if (nr52[7]) begin
      for (int i = 0; i < 4; i++) begin
        if (nr51[4+i]) l += t[i];
        if (nr51[i])   r += t[i];
      end
    end
    l = (l * (int'(nr50[6:4]) + 1)) >>> 3;
    r = (r * (int'(nr50[2:0]) + 1)) >>> 3;
    if (ratio == 2'd1) begin l = l >>> 1; r = r >>> 1; end
    else if (ratio != 2'd2) begin l = l >>> 2; r = r >>> 2; end
    p.l = 16'(clamp16(l));
    p.r = 16'(clamp16(r));
    return p;
  endfunction

  // Drives a one-cycle tick from a negedge and records the expected pair.
  task automatic do_tick();
    sb.push_back(model());
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Waits (bounded) for valid; called on the negedge just after the tick.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!sample_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic collect(input string tag);
    pair_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_left"}, 32'(left_sample), 32'(e.l));
      check({tag, "_right"}, 32'(right_sample), 32'(e.r));
    end
  endtask

  task automatic set_ch(input logic [23:0] a, b, c, d);
    ch1 = a; ch2 = b; ch3 = c; ch4 = d;
  endtask

  initial begin
    int    cyc;
    bit    seen;
    logic [15:0] hold_l, hold_r;

    reset = 1'b1; sample_tick = 1'b0; sample_ready = 1'b0;
    set_ch(24'h0, 24'h0, 24'h0, 24'h0);
    nr50 = 8'h00; nr51 = 8'h00; nr52 = 8'h80; ratio = 2'd2;
    repeat (2) @(negedge clk);
    check("rst_left", 32'(left_sample), 32'h0);
    check("rst_right", 32'(right_sample), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single channel, unity volume, latency and tick-on-return boundary
    set_ch(24'h010000, 24'h0, 24'h0, 24'h0);
    nr51 = 8'h11; nr50 = 8'h77; ratio = 2'd2; sample_ready = 1'b1;
    do_tick();
    check("t1_busy", 32'(busy), 32'h1);
    wait_valid(cyc);
    check("t1_latency", 32'(cyc), 32'd7);
    check("t1_left_const", 32'(left_sample), 32'h0100);
    check("t1_right_const", 32'(right_sample), 32'h0100);
    collect("t1");
    sample_tick = 1'b1;              // lands on the OUT->IDLE edge: dropped
    @(negedge clk);
    sample_tick = 1'b0;
    check("t1_valid_drop", 32'(sample_valid), 32'h0);
    check("t1_busy_idle", 32'(busy), 32'h0);
    check("t1_overrun_edge", 32'(overrun), 32'h1);
    do_tick();                       // earliest accepted tick
    check("t1b_busy", 32'(busy), 32'h1);
    wait_valid(cyc);
    check("t1b_latency", 32'(cyc), 32'd7);
    collect("t1b");
    @(negedge clk);

    // 2: positive and negative saturation
    set_ch(24'h7FFF00, 24'h7FFF00, 24'h7FFF00, 24'h7FFF00);
    nr51 = 8'hFF; nr50 = 8'h77; ratio = 2'd2;
    do_tick(); wait_valid(cyc);
    check("t2_pos_const", 32'({left_sample, right_sample}), 32'h7FFF7FFF);
    collect("t2_pos");
    @(negedge clk);
    set_ch(24'h800000, 24'h800000, 24'h800000, 24'h800000);
    do_tick(); wait_valid(cyc);
    check("t2_neg_const", 32'({left_sample, right_sample}), 32'h80008000);
    collect("t2_neg");
    @(negedge clk);

    // 3: left-only routing, volume 3, ratio 50%
    set_ch(24'h0, 24'h040000, 24'h0, 24'h0);
    nr51 = 8'h20; nr50 = 8'h30; ratio = 2'd1;
    do_tick(); wait_valid(cyc);
    check("t3_const", 32'({left_sample, right_sample}), 32'h01000000);
    collect("t3");
    @(negedge clk);

    // 5a: master off clears the overrun left from test 1
    nr52 = 8'h00;
    set_ch(24'h123400, 24'h0F0000, 24'h333300, 24'hF00000);
    nr51 = 8'hFF; nr50 = 8'h77; ratio = 2'd2;
    do_tick();
    check("t5a_overrun_clr", 32'(overrun), 32'h0);
    wait_valid(cyc);
    collect("t5a");
    @(negedge clk);

    // 4: backpressure with dropped ticks; mixed signs, ratio 25%
    nr52 = 8'h80;
    set_ch(24'h0, 24'h0, 24'h123400, 24'hFF0000);
    nr51 = 8'h4C; nr50 = 8'h52; ratio = 2'd0; sample_ready = 1'b0;
    do_tick(); wait_valid(cyc);
    check("t4_latency", 32'(cyc), 32'd7);
    hold_l = left_sample; hold_r = right_sample;
    collect("t4");
    set_ch(24'h7FFF00, 24'h7FFF00, 24'h7FFF00, 24'h7FFF00);
    sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0; @(negedge clk);
    sample_tick = 1'b1; @(negedge clk); sample_tick = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_hold_left", 32'(left_sample), 32'(hold_l));
    check("t4_hold_right", 32'(right_sample), 32'(hold_r));
    check("t4_hold_valid", 32'(sample_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    sample_ready = 1'b1;
    @(negedge clk);
    check("t4_valid_drop", 32'(sample_valid), 32'h0);
    check("t4_busy_idle", 32'(busy), 32'h0);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (sample_valid) seen = 1'b1; end
    check("t4_no_new", 32'(seen), 32'h0);

    // 5b: master off, nonzero channels, outputs zero and overrun clears
    nr52 = 8'h00;
    do_tick();
    check("t5_overrun_clr", 32'(overrun), 32'h0);
    wait_valid(cyc);
    check("t5_latency", 32'(cyc), 32'd7);
    check("t5_zero", 32'({left_sample, right_sample}), 32'h0);
    collect("t5");
    @(negedge clk);

    // 6: nonzero sample, then reset during ACC2, then fresh sample
    nr52 = 8'h80;
    set_ch(24'h020000, 24'hFF8000, 24'h001000, 24'h0);
    nr51 = 8'h37; nr50 = 8'h64; ratio = 2'd3;
    do_tick(); wait_valid(cyc);
    collect("t6_pre");
    @(negedge clk);
    set_ch(24'h300000, 24'h0, 24'h0, 24'h0);
    nr51 = 8'h11; nr50 = 8'h77; ratio = 2'd2;
    do_tick();                       // now in ACC0
    repeat (2) @(negedge clk);       // now in ACC2
    reset = 1'b1;
    #1;
    check("t6_rst_left", 32'(left_sample), 32'h0);
    check("t6_rst_right", 32'(right_sample), 32'h0);
    check("t6_rst_valid", 32'(sample_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    void'(sb.pop_back());            // aborted sample never appears
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (sample_valid) seen = 1'b1; end
    check("t6_no_pulse", 32'(seen), 32'h0);
    do_tick(); wait_valid(cyc);
    check("t6_latency", 32'(cyc), 32'd7);
    check("t6_fresh_const", 32'({left_sample, right_sample}), 32'h30003000);
    collect("t6");
    @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
